// File: rtl/pe_ws_pkg.sv
// Shared definitions for the weight-stationary PE sequencer: ctrl bit map,
// FSM state encoding and the ctrl-word builder.
package pe_ws_pkg;

  localparam int CTRL_RD = 0;
  localparam int CTRL_TM = 3;
  localparam int CTRL_TK = 5;
  localparam int CTRL_TN = 7;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    COMPUTE = 2'd2
  } state_t;

  // Callers zero-extend the 8-bit result to their ctrl NOC width.
  function automatic logic [7:0] build_ctrl(input logic rd, input logic tm,
                                            input logic tk, input logic tn);
    logic [7:0] c;
    c          = '0;
    c[CTRL_RD] = rd;
    c[CTRL_TM] = tm;
    c[CTRL_TK] = tk;
    c[CTRL_TN] = tn;
    return c;
  endfunction

endpackage

// File: rtl/pe_ws_loop_cnt.sv
// Four-level nested loop counter (m outer, k, n, s inner) advancing once per
// enabled cycle; exposes per-level last flags and a whole-nest wrap.
module pe_ws_loop_cnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [CNT_WIDTH-1:0] i_cfg_s,
  input  logic [CNT_WIDTH-1:0] i_cfg_n,
  input  logic [CNT_WIDTH-1:0] i_cfg_k,
  input  logic [CNT_WIDTH-1:0] i_cfg_m,
  output logic                 o_s_last,
  output logic                 o_n_last,
  output logic                 o_k_last,
  output logic                 o_wrap
);

  logic [CNT_WIDTH-1:0] r_s, r_n, r_k, r_m;
  logic                 w_s_last, w_n_last, w_k_last, w_m_last;

  assign w_s_last = (r_s == i_cfg_s - CNT_WIDTH'(1));
  assign w_n_last = (r_n == i_cfg_n - CNT_WIDTH'(1));
  assign w_k_last = (r_k == i_cfg_k - CNT_WIDTH'(1));
  assign w_m_last = (r_m == i_cfg_m - CNT_WIDTH'(1));

  assign o_s_last = w_s_last;
  assign o_n_last = w_n_last;
  assign o_k_last = w_k_last;
  assign o_wrap   = i_en & w_s_last & w_n_last & w_k_last & w_m_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s <= '0;
      r_n <= '0;
      r_k <= '0;
      r_m <= '0;
    end else if (i_clr) begin
      r_s <= '0;
      r_n <= '0;
      r_k <= '0;
      r_m <= '0;
    end else if (i_en) begin
      if (!w_s_last) begin
        r_s <= r_s + CNT_WIDTH'(1);
      end else begin
        r_s <= '0;
        if (!w_n_last) begin
          r_n <= r_n + CNT_WIDTH'(1);
        end else begin
          r_n <= '0;
          if (!w_k_last) begin
            r_k <= r_k + CNT_WIDTH'(1);
          end else begin
            r_k <= '0;
            r_m <= w_m_last ? '0 : r_m + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/pe_ws_seq.sv
// Weight/ctrl NOC transmitter for one weight-stationary PE: loads S*K weights,
// then issues the M*K*N*S read-beat ctrl sequence with a PE pointer model.
module pe_ws_seq
  import pe_ws_pkg::*;
#(
  parameter int OP_WIDTH   = 8,
  parameter int CTRL_WIDTH = 9,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  cfg_s,
  input  logic [CNT_WIDTH-1:0]  cfg_n,
  input  logic [CNT_WIDTH-1:0]  cfg_k,
  input  logic [CNT_WIDTH-1:0]  cfg_m,
  input  logic                  w_valid,
  input  logic [OP_WIDTH-1:0]   w_data,
  output logic                  w_ready,
  input  logic                  stall,
  output logic                  wctrl,
  output logic [OP_WIDTH-1:0]   weight,
  output logic [CTRL_WIDTH-1:0] ctrl,
  output logic [ADDR_WIDTH-1:0] exp_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  state_t                 r_state;
  logic [CNT_WIDTH-1:0]   r_cfg_s, r_cfg_n, r_cfg_k, r_cfg_m;
  logic [2*CNT_WIDTH-1:0] r_load_cnt, r_load_last;
  logic [ADDR_WIDTH-1:0]  r_ptr, r_off, r_exp_addr;
  logic [CTRL_WIDTH-1:0]  r_ctrl;
  logic [OP_WIDTH-1:0]    r_weight;
  logic                   r_wctrl, r_busy, r_done, r_err, r_fin;

  logic [2*CNT_WIDTH-1:0] w_prod;
  logic                   w_accept, w_cfg_bad, w_beat;
  logic                   w_s_last, w_n_last, w_k_last, w_wrap;
  logic                   w_tn, w_tk, w_tm;

  assign w_prod    = {{CNT_WIDTH{1'b0}}, cfg_s} * {{CNT_WIDTH{1'b0}}, cfg_k};
  assign w_cfg_bad = (cfg_s == '0) || (cfg_n == '0) || (cfg_k == '0) ||
                     (cfg_m == '0) || (32'(w_prod) > (32'd1 << ADDR_WIDTH));
  // busy stays high until done, so a start in the trailing IDLE cycle is ignored
  assign w_accept  = start && (r_state == IDLE) && !r_busy;
  assign w_beat    = (r_state == COMPUTE) && !stall;

  assign w_tn = w_s_last & ~w_n_last;
  assign w_tk = w_s_last &  w_n_last & ~w_k_last;
  assign w_tm = w_s_last &  w_n_last &  w_k_last;

  pe_ws_loop_cnt #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_loop_cnt (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (r_state != COMPUTE),
    .i_en     (w_beat),
    .i_cfg_s  (r_cfg_s),
    .i_cfg_n  (r_cfg_n),
    .i_cfg_k  (r_cfg_k),
    .i_cfg_m  (r_cfg_m),
    .o_s_last (w_s_last),
    .o_n_last (w_n_last),
    .o_k_last (w_k_last),
    .o_wrap   (w_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cfg_s     <= '0;
      r_cfg_n     <= '0;
      r_cfg_k     <= '0;
      r_cfg_m     <= '0;
      r_load_cnt  <= '0;
      r_load_last <= '0;
      r_ptr       <= '0;
      r_off       <= '0;
      r_exp_addr  <= '0;
      r_ctrl      <= '0;
      r_weight    <= '0;
      r_wctrl     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_fin       <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fin   <= 1'b0;
      r_wctrl <= 1'b0;
      r_ctrl  <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cfg_s     <= cfg_s;
            r_cfg_n     <= cfg_n;
            r_cfg_k     <= cfg_k;
            r_cfg_m     <= cfg_m;
            r_err       <= w_cfg_bad;
            r_load_cnt  <= '0;
            r_load_last <= w_prod - (2*CNT_WIDTH)'(1);
            if (w_cfg_bad) begin
              r_done <= 1'b1;
            end else begin
              r_state <= LOAD;
              r_busy  <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_ptr <= '0;
          r_off <= '0;
          if (w_valid) begin
            r_wctrl    <= 1'b1;
            r_weight   <= w_data;
            r_load_cnt <= r_load_cnt + (2*CNT_WIDTH)'(1);
            if (r_load_cnt == r_load_last) begin
              r_state <= COMPUTE;
            end
          end
        end
        COMPUTE: begin
          if (!stall) begin
            r_ctrl     <= CTRL_WIDTH'(build_ctrl(1'b1, w_tm, w_tk, w_tn));
            r_exp_addr <= r_ptr;
            if (w_tm) begin
              r_ptr <= '0;
              r_off <= '0;
            end else if (w_tk) begin
              r_ptr <= r_ptr + ADDR_WIDTH'(1);
              r_off <= r_ptr + ADDR_WIDTH'(1);
            end else if (w_tn) begin
              r_ptr <= r_off;
            end else begin
              r_ptr <= r_ptr + ADDR_WIDTH'(1);
            end
            if (w_wrap) begin
              r_state <= IDLE;
              r_fin   <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
      // done trails the final beat by one cycle; busy falls together with it
      if (r_fin) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign w_ready  = (r_state == LOAD);
  assign wctrl    = r_wctrl;
  assign weight   = r_weight;
  assign ctrl     = r_ctrl;
  assign exp_addr = r_exp_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_pe_ws_seq.sv
// Directed bench for pe_ws_seq: table of configs with expected totals, a
// reference beat model, plus stall, busy-start and mid-load reset sequences.
module tb_pe_ws_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] cfg_s = '0, cfg_n = '0, cfg_k = '0, cfg_m = '0;
  logic       w_valid = 1'b0;
  logic [7:0] w_data = '0;
  logic       w_ready;
  logic       stall = 1'b0;
  logic       wctrl;
  logic [7:0] weight;
  logic [8:0] ctrl;
  logic [9:0] exp_addr;
  logic       busy, done, err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pe_ws_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cfg_s    (cfg_s),
    .cfg_n    (cfg_n),
    .cfg_k    (cfg_k),
    .cfg_m    (cfg_m),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_ready  (w_ready),
    .stall    (stall),
    .wctrl    (wctrl),
    .weight   (weight),
    .ctrl     (ctrl),
    .exp_addr (exp_addr),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  typedef struct {
    int s, k, n, m;
    bit tog;
    int stall_at, stall_len, busy_at;
    bit exp_err;
    int exp_pulses, exp_beats;
  } case_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic run_case(input int idx, input case_t c);
    int  exp_c[$];
    int  exp_a[$];
    int  ptr, off, cv;
    int  pulses, beats, last_beat_cyc, last_w, last_addr, stall_rem, sent, budget;
    bit  stall_started, busy_fired, prev_stall, seen_done, vtog;

    ptr = 0; off = 0;
    if (!c.exp_err) begin
      for (int m = 0; m < c.m; m++)
        for (int k = 0; k < c.k; k++)
          for (int n = 0; n < c.n; n++)
            for (int s = 0; s < c.s; s++) begin
              cv = 1;
              if (s == c.s - 1) begin
                if (n < c.n - 1)      cv = 'h81;
                else if (k < c.k - 1) cv = 'h21;
                else                  cv = 'h09;
              end
              exp_c.push_back(cv);
              exp_a.push_back(ptr);
              if (cv == 'h09)      begin ptr = 0; off = 0; end
              else if (cv == 'h21) begin ptr = ptr + 1; off = ptr; end
              else if (cv == 'h81) ptr = off;
              else                 ptr = ptr + 1;
            end
    end

    pulses = 0; beats = 0; last_beat_cyc = -10; last_w = 0; last_addr = 0;
    stall_rem = 0; sent = 0; stall_started = 0; busy_fired = 0;
    seen_done = 0; vtog = 0;
    budget = c.s * c.k * 3 + c.m * c.n * c.k * c.s * 2 + 100;

    @(negedge clk);
    cfg_s = 8'(c.s); cfg_k = 8'(c.k); cfg_n = 8'(c.n); cfg_m = 8'(c.m);
    start = 1'b1; w_valid = 1'b0;

    for (int cyc = 0; cyc < budget && !seen_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      prev_stall = stall;
      if (cyc == 0 && !c.exp_err) chk("busy_after_start", int'(busy), 1);
      if (wctrl) begin
        chk("weight_data", int'(weight), pulses % 256);
        last_w = int'(weight);
        pulses++;
      end else if (pulses > 0 && pulses < c.exp_pulses) begin
        chk("weight_hold", int'(weight), last_w);
      end
      if (prev_stall) begin
        chk("stall_ctrl", int'(ctrl), 0);
        chk("stall_addr", int'(exp_addr), last_addr);
      end else if (ctrl != '0) begin
        if (beats < exp_c.size()) begin
          chk($sformatf("ctrl_beat%0d", beats), int'(ctrl), exp_c[beats]);
          chk($sformatf("addr_beat%0d", beats), int'(exp_addr), exp_a[beats]);
        end else begin
          chk("extra_beat", beats + 1, exp_c.size());
        end
        last_addr = int'(exp_addr);
        last_beat_cyc = cyc;
        beats++;
      end
      if (done) begin
        seen_done = 1;
        if (c.exp_err) chk("err_done_cycle", cyc, 0);
        else           chk("done_cycle", cyc, last_beat_cyc + 1);
        chk("busy_at_done", int'(busy), 0);
        chk("err_at_done", int'(err), int'(c.exp_err));
      end
      if (!stall_started && c.stall_len > 0 && beats == c.stall_at) begin
        stall_started = 1;
        stall_rem = c.stall_len;
      end
      if (stall_rem > 0) begin stall = 1'b1; stall_rem--; end
      else stall = 1'b0;
      if (!busy_fired && c.busy_at >= 0 && beats == c.busy_at) begin
        busy_fired = 1;
        start = 1'b1;
        cfg_s = 8'd1; cfg_k = 8'd1; cfg_n = 8'd1; cfg_m = 8'd1;
      end
      if (w_ready) begin
        vtog    = c.tog ? ~vtog : 1'b1;
        w_valid = vtog;
        w_data  = vtog ? sent[7:0] : 8'hAA;
        if (vtog) sent++;
      end else begin
        w_valid = 1'b0;
      end
    end
    w_valid = 1'b0; stall = 1'b0; start = 1'b0;
    chk("done_seen", int'(seen_done), 1);
    chk("wctrl_total", pulses, c.exp_pulses);
    chk("beat_total", beats, c.exp_beats);
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("err_sticky", int'(err), int'(c.exp_err));
    $display("case %0d S=%0d K=%0d N=%0d M=%0d pulses=%0d beats=%0d err=%0d",
             idx, c.s, c.k, c.n, c.m, pulses, beats, err);
  endtask

  case_t cases[9];
  int    nload;

  initial begin
    cases[0] = '{4, 2, 3, 2, 0, -1, 0, -1, 0, 8, 48};
    cases[1] = '{4, 2, 3, 2, 1, -1, 0, -1, 0, 8, 48};
    cases[2] = '{4, 2, 3, 2, 0, 20, 5, 30, 0, 8, 48};
    cases[3] = '{4, 0, 3, 2, 0, -1, 0, -1, 1, 0, 0};
    cases[4] = '{64, 17, 1, 1, 0, -1, 0, -1, 1, 0, 0};
    cases[5] = '{1, 1, 1, 1, 0, -1, 0, -1, 0, 1, 1};
    cases[6] = '{3, 1, 2, 1, 1, -1, 0, -1, 0, 3, 6};
    cases[7] = '{2, 2, 2, 0, 0, -1, 0, -1, 1, 0, 0};
    cases[8] = '{32, 32, 1, 1, 0, -1, 0, -1, 0, 1024, 1024};

    #1;
    chk("rst_w_ready", int'(w_ready), 0);
    chk("rst_wctrl", int'(wctrl), 0);
    chk("rst_ctrl", int'(ctrl), 0);
    chk("rst_exp_addr", int'(exp_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done_err", int'({done, err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_case(i, cases[i]);

    // Reset in the middle of a load, then a clean full run
    @(negedge clk);
    cfg_s = 8'd4; cfg_k = 8'd2; cfg_n = 8'd3; cfg_m = 8'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; w_valid = 1'b1; w_data = 8'h55;
    nload = 0;
    for (int cyc = 0; cyc < 20 && nload < 3; cyc++) begin
      @(negedge clk);
      if (wctrl) nload++;
    end
    chk("midload_pulses", nload, 3);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_wctrl", int'(wctrl), 0);
    chk("async_rst_weight", int'(weight), 0);
    chk("async_rst_w_ready", int'(w_ready), 0);
    chk("async_rst_busy", int'(busy), 0);
    $display("midload reset: pulses_before=%0d wctrl=%0d weight=%0d busy=%0d",
             nload, wctrl, weight, busy);
    @(negedge clk);
    rst = 1'b0; w_valid = 1'b0;
    run_case(9, cases[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
